// File: rtl/slot_pkg.sv
// Shared types and constants for the slot machine credit path.
// Widths, credit bounds, payout multipliers and the ledger state encoding live here.
package slot_pkg;

   localparam int NUM_W = 11;
   localparam int BET_W = 4;
   localparam int SYM_W = 3;
   localparam int WIN_W = 9;
   localparam int SUM_W = 12;
   localparam int MULT_W = 5;

   localparam int CREDIT_MAX = 999;
   localparam int CREDIT_MIN = -999;

   localparam logic signed [SUM_W-1:0] CREDIT_MAX_S = SUM_W'(CREDIT_MAX);
   localparam logic signed [SUM_W-1:0] CREDIT_MIN_S = SUM_W'(CREDIT_MIN);

   localparam logic [MULT_W-1:0] MULT_JACKPOT = 5'd20;
   localparam logic [MULT_W-1:0] MULT_TRIPLE  = 5'd10;
   localparam logic [MULT_W-1:0] MULT_PAIR    = 5'd2;
   localparam logic [SYM_W-1:0]  JACKPOT_SYM  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_SPIN = 2'd1,
      ST_PAYOUT    = 2'd2
   } ledger_state_e;

   // The display only has three digits, so every balance update goes through this clamp.
   function automatic logic signed [SUM_W-1:0] sat_credit(input logic signed [SUM_W-1:0] value);
      if (value > CREDIT_MAX_S) begin
         return CREDIT_MAX_S;
      end
      if (value < CREDIT_MIN_S) begin
         return CREDIT_MIN_S;
      end
      return value;
   endfunction

endpackage

// File: rtl/payout_eval.sv
// Combinational payout: symbol-match multiplier times the wager.
// Maximum result is 15 * 20 = 300, which fits the 9-bit output.
module payout_eval
   import slot_pkg::*;
(
   input  logic [SYM_W-1:0] reel0,
   input  logic [SYM_W-1:0] reel1,
   input  logic [SYM_W-1:0] reel2,
   input  logic [BET_W-1:0] bet,
   output logic [WIN_W-1:0] payout
);

   logic [MULT_W-1:0] mult;
   logic              all_equal;
   logic              any_pair;

   assign all_equal = (reel0 == reel1) && (reel1 == reel2);
   assign any_pair  = (reel0 == reel1) || (reel1 == reel2) || (reel0 == reel2);

   always_comb begin
      mult = '0;
      if (all_equal) begin
         mult = (reel0 == JACKPOT_SYM) ? MULT_JACKPOT : MULT_TRIPLE;
      end else if (any_pair) begin
         mult = MULT_PAIR;
      end
   end

   assign payout = WIN_W'(mult) * WIN_W'(bet);

endmodule

// File: rtl/credit_ledger.sv
// Player credit ledger: debits bets, launches spins, credits payouts back to the balance.
// Define SPIN_TIMEOUT_EN to add a spin watchdog that refunds the bet after TIMEOUT_CYCLES.
module credit_ledger
   import slot_pkg::*;
#(
   parameter int INIT_CREDITS   = 100,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bet_req,
   input  logic [BET_W-1:0] bet_amt,
   input  logic             spin_done,
   input  logic [SYM_W-1:0] reel0,
   input  logic [SYM_W-1:0] reel1,
   input  logic [SYM_W-1:0] reel2,
   output logic             spin_start,
   output logic [NUM_W-1:0] number,
   output logic [WIN_W-1:0] last_win,
   output logic             bet_rej,
   output logic             busy
);

   localparam logic signed [NUM_W-1:0] INIT_NUM = NUM_W'(INIT_CREDITS);

   if (INIT_CREDITS > CREDIT_MAX || INIT_CREDITS < CREDIT_MIN || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("credit_ledger: INIT_CREDITS must be within -999..999 and TIMEOUT_CYCLES >= 1");
   end

   ledger_state_e           state_q, state_d;
   logic signed [NUM_W-1:0] number_q, number_d;
   logic [WIN_W-1:0]        last_win_q, last_win_d;
   logic                    spin_start_q, spin_start_d;
   logic                    bet_rej_q, bet_rej_d;
   logic [BET_W-1:0]        bet_q, bet_d;
   logic [SYM_W-1:0]        reel0_q, reel0_d;
   logic [SYM_W-1:0]        reel1_q, reel1_d;
   logic [SYM_W-1:0]        reel2_q, reel2_d;

   logic [WIN_W-1:0]        payout;
   logic signed [SUM_W-1:0] number_ext;
   logic signed [SUM_W-1:0] bet_amt_ext;
   logic signed [SUM_W-1:0] payout_ext;
   logic signed [SUM_W-1:0] debit_sum;
   logic signed [SUM_W-1:0] credit_sum;

`ifdef SPIN_TIMEOUT_EN
   localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

   logic [TIMER_W-1:0]      timer_q, timer_d;
   logic signed [SUM_W-1:0] bet_latched_ext;
   logic signed [SUM_W-1:0] refund_sum;

   assign bet_latched_ext = signed'(SUM_W'(bet_q));
   assign refund_sum      = number_ext + bet_latched_ext;
`endif

   payout_eval u_payout_eval (
      .reel0  (reel0_q),
      .reel1  (reel1_q),
      .reel2  (reel2_q),
      .bet    (bet_q),
      .payout (payout)
   );

   // 12-bit signed arithmetic leaves headroom for 999 + 300 and -999 - 15.
   assign number_ext  = SUM_W'(number_q);
   assign bet_amt_ext = signed'(SUM_W'(bet_amt));
   assign payout_ext  = signed'(SUM_W'(payout));
   assign debit_sum   = number_ext - bet_amt_ext;
   assign credit_sum  = number_ext + payout_ext;

   always_comb begin
      state_d      = state_q;
      number_d     = number_q;
      last_win_d   = last_win_q;
      spin_start_d = 1'b0;
      bet_rej_d    = 1'b0;
      bet_d        = bet_q;
      reel0_d      = reel0_q;
      reel1_d      = reel1_q;
      reel2_d      = reel2_q;
`ifdef SPIN_TIMEOUT_EN
      timer_d      = timer_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (bet_req && (bet_amt != '0)) begin
               if (debit_sum >= CREDIT_MIN_S) begin
                  number_d     = NUM_W'(debit_sum);
                  bet_d        = bet_amt;
                  spin_start_d = 1'b1;
                  state_d      = ST_WAIT_SPIN;
`ifdef SPIN_TIMEOUT_EN
                  timer_d      = '0;
`endif
               end else begin
                  bet_rej_d = 1'b1;
               end
            end
         end

         // A spin_done coinciding with our own spin_start pulse cannot belong to this spin.
         ST_WAIT_SPIN: begin
            if (spin_done && !spin_start_q) begin
               reel0_d = reel0;
               reel1_d = reel1;
               reel2_d = reel2;
               state_d = ST_PAYOUT;
`ifdef SPIN_TIMEOUT_EN
            end else if (timer_q == TIMER_LAST) begin
               number_d   = NUM_W'(sat_credit(refund_sum));
               last_win_d = '0;
               state_d    = ST_IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
`endif
            end
         end

         ST_PAYOUT: begin
            number_d   = NUM_W'(sat_credit(credit_sum));
            last_win_d = payout;
            state_d    = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         number_q     <= INIT_NUM;
         last_win_q   <= '0;
         spin_start_q <= 1'b0;
         bet_rej_q    <= 1'b0;
         bet_q        <= '0;
         reel0_q      <= '0;
         reel1_q      <= '0;
         reel2_q      <= '0;
`ifdef SPIN_TIMEOUT_EN
         timer_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         number_q     <= number_d;
         last_win_q   <= last_win_d;
         spin_start_q <= spin_start_d;
         bet_rej_q    <= bet_rej_d;
         bet_q        <= bet_d;
         reel0_q      <= reel0_d;
         reel1_q      <= reel1_d;
         reel2_q      <= reel2_d;
`ifdef SPIN_TIMEOUT_EN
         timer_q      <= timer_d;
`endif
      end
   end

   assign spin_start = spin_start_q;
   assign number     = number_q;
   assign last_win   = last_win_q;
   assign bet_rej    = bet_rej_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_credit_ledger.sv
// Self-checking bench for credit_ledger with a behavioural balance model.
// Timeout scenarios run only when SPIN_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 10 here).
module tb_credit_ledger;

   logic        clk = 1'b0;
   logic        rst;
   logic        bet_req;
   logic [3:0]  bet_amt;
   logic        spin_done;
   logic [2:0]  reel0, reel1, reel2;
   logic        spin_start;
   logic [10:0] number;
   logic [8:0]  last_win;
   logic        bet_rej;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;
   int bal;
   int last_pay;

   always #5 clk = ~clk;

   credit_ledger #(
      .INIT_CREDITS   (100),
      .TIMEOUT_CYCLES (10)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bet_req    (bet_req),
      .bet_amt    (bet_amt),
      .spin_done  (spin_done),
      .reel0      (reel0),
      .reel1      (reel1),
      .reel2      (reel2),
      .spin_start (spin_start),
      .number     (number),
      .last_win   (last_win),
      .bet_rej    (bet_rej),
      .busy       (busy)
   );

   // Multiplier from the number of distinct symbols showing.
   function automatic int model_mult(input int r0, input int r1, input int r2);
      int distinct;
      distinct = 1;
      if (r1 != r0) distinct++;
      if (r2 != r0 && r2 != r1) distinct++;
      if (distinct == 1) return (r0 == 7) ? 20 : 10;
      if (distinct == 2) return 2;
      return 0;
   endfunction

   function automatic logic [10:0] enc(input int v);
      logic [10:0] r;
      r = 11'(v);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bet_req   = 1'b0;
      bet_amt   = 4'd0;
      spin_done = 1'b0;
      reel0     = 3'd0;
      reel1     = 3'd0;
      reel2     = 3'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      bal      = 100;
      last_pay = 0;
   endtask

   // One complete bet attempt, checked against the model balance.
   task automatic spin_txn(input int bet, input int r0, input int r1, input int r2, input int delay);
      int pay;
      bet_req = 1'b1;
      bet_amt = 4'(bet);
      tick();
      bet_req = 1'b0;
      bet_amt = 4'd0;
      if (bet == 0) begin
         n_checks++; if (spin_start !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_bet_spin_start: got %b want 0", spin_start); end
         n_checks++; if (bet_rej !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_bet_rej: got %b want 0", bet_rej); end
         n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_bet_busy: got %b want 0", busy); end
      end else if (bal - bet < -999) begin
         n_checks++; if (bet_rej !== 1'b1) begin n_fail++; $display("[TB] FAIL rej_pulse: got %b want 1", bet_rej); end
         n_checks++; if (spin_start !== 1'b0) begin n_fail++; $display("[TB] FAIL rej_spin_start: got %b want 0", spin_start); end
         n_checks++; if (number !== enc(bal)) begin n_fail++; $display("[TB] FAIL rej_number: got %0d want %0d", $signed(number), bal); end
         tick();
         n_checks++; if (bet_rej !== 1'b0) begin n_fail++; $display("[TB] FAIL rej_pulse_width: got %b want 0", bet_rej); end
         n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rej_busy: got %b want 0", busy); end
      end else begin
         bal = bal - bet;
         n_checks++; if (number !== enc(bal)) begin n_fail++; $display("[TB] FAIL debit_number: got %0d want %0d", $signed(number), bal); end
         n_checks++; if (spin_start !== 1'b1) begin n_fail++; $display("[TB] FAIL spin_start_pulse: got %b want 1", spin_start); end
         n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL debit_busy: got %b want 1", busy); end
         tick();
         n_checks++; if (spin_start !== 1'b0) begin n_fail++; $display("[TB] FAIL spin_start_width: got %b want 0", spin_start); end
         repeat (delay) tick();
         spin_done = 1'b1;
         reel0 = 3'(r0);
         reel1 = 3'(r1);
         reel2 = 3'(r2);
         tick();
         spin_done = 1'b0;
         n_checks++; if (number !== enc(bal)) begin n_fail++; $display("[TB] FAIL payout_early: got %0d want %0d", $signed(number), bal); end
         n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL payout_busy: got %b want 1", busy); end
         tick();
         pay = model_mult(r0, r1, r2) * bet;
         bal = (bal + pay > 999) ? 999 : bal + pay;
         last_pay = pay;
         n_checks++; if (number !== enc(bal)) begin n_fail++; $display("[TB] FAIL credit_number: got %0d want %0d", $signed(number), bal); end
         n_checks++; if (last_win !== 9'(pay)) begin n_fail++; $display("[TB] FAIL last_win: got %0d want %0d", last_win, pay); end
         n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_busy: got %b want 0", busy); end
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      n_checks++; if (number !== 11'd100) begin n_fail++; $display("[TB] FAIL reset_number: got %0d want 100", $signed(number)); end
      n_checks++; if (last_win !== 9'd0) begin n_fail++; $display("[TB] FAIL reset_last_win: got %0d want 0", last_win); end
      n_checks++; if (spin_start !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_spin_start: got %b want 0", spin_start); end
      n_checks++; if (bet_rej !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_bet_rej: got %b want 0", bet_rej); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      rst = 1'b0;
      bal = 100;
   endtask

   task automatic test_basic();
      do_reset();
      spin_txn(5, 3, 3, 3, 0);
      n_checks++; if (number !== 11'd145) begin n_fail++; $display("[TB] FAIL basic_number: got %0d want 145", $signed(number)); end
      n_checks++; if (last_win !== 9'd50) begin n_fail++; $display("[TB] FAIL basic_last_win: got %0d want 50", last_win); end
   endtask

   task automatic test_saturation();
      do_reset();
      repeat (3) spin_txn(15, 7, 7, 7, 0);
      spin_txn(15, 4, 4, 1, 1);
      spin_txn(15, 2, 5, 5, 0);
      spin_txn(5, 6, 0, 6, 2);
      n_checks++; if (number !== 11'd990) begin n_fail++; $display("[TB] FAIL sat_setup: got %0d want 990", $signed(number)); end
      spin_txn(15, 7, 7, 7, 0);
      n_checks++; if (number !== 11'd999) begin n_fail++; $display("[TB] FAIL sat_number: got %0d want 999", $signed(number)); end
      n_checks++; if (last_win !== 9'd300) begin n_fail++; $display("[TB] FAIL sat_last_win: got %0d want 300", last_win); end
   endtask

   task automatic test_reject();
      logic [10:0] min_code;
      do_reset();
      repeat (72) spin_txn(15, 0, 1, 2, 0);
      spin_txn(10, 5, 3, 1, 0);
      n_checks++; if (number !== 11'h422) begin n_fail++; $display("[TB] FAIL neg_setup: got %0h want 422", number); end
      spin_txn(10, 0, 1, 2, 0);
      n_checks++; if (number !== 11'h422) begin n_fail++; $display("[TB] FAIL reject_hold: got %0h want 422", number); end
      spin_txn(9, 0, 1, 2, 0);
      min_code = 11'h419;
      n_checks++; if (number !== min_code) begin n_fail++; $display("[TB] FAIL floor_number: got %0h want %0h", number, min_code); end
      spin_txn(1, 0, 1, 2, 0);
   endtask

   task automatic test_wait_spin();
      do_reset();
      bet_req = 1'b1;
      bet_amt = 4'd3;
      tick();
      n_checks++; if (number !== 11'd97) begin n_fail++; $display("[TB] FAIL wait_debit: got %0d want 97", $signed(number)); end
      bet_amt   = 4'd4;
      spin_done = 1'b1;
      reel0 = 3'd7; reel1 = 3'd7; reel2 = 3'd7;
      tick();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL early_done_busy: got %b want 1", busy); end
      n_checks++; if (bet_rej !== 1'b0) begin n_fail++; $display("[TB] FAIL wait_bet_rej: got %b want 0", bet_rej); end
      n_checks++; if (spin_start !== 1'b0) begin n_fail++; $display("[TB] FAIL wait_bet_spin: got %b want 0", spin_start); end
      reel0 = 3'd1; reel1 = 3'd2; reel2 = 3'd1;
      tick();
      bet_req   = 1'b0;
      spin_done = 1'b0;
      n_checks++; if (number !== 11'd97) begin n_fail++; $display("[TB] FAIL wait_hold: got %0d want 97", $signed(number)); end
      n_checks++; if (bet_rej !== 1'b0) begin n_fail++; $display("[TB] FAIL wait_bet_rej2: got %b want 0", bet_rej); end
      tick();
      n_checks++; if (number !== 11'd103) begin n_fail++; $display("[TB] FAIL pair_number: got %0d want 103", $signed(number)); end
      n_checks++; if (last_win !== 9'd6) begin n_fail++; $display("[TB] FAIL pair_last_win: got %0d want 6", last_win); end
      bal = 103;
      spin_txn(5, 0, 1, 2, 1);
      spin_done = 1'b1;
      reel0 = 3'd7; reel1 = 3'd7; reel2 = 3'd7;
      tick();
      spin_done = 1'b0;
      tick();
      n_checks++; if (number !== enc(bal)) begin n_fail++; $display("[TB] FAIL idle_done_number: got %0d want %0d", $signed(number), bal); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_done_busy: got %b want 0", busy); end
      n_checks++; if (last_win !== 9'd0) begin n_fail++; $display("[TB] FAIL idle_done_win: got %0d want 0", last_win); end
   endtask

   task automatic test_reset_mid_spin();
      do_reset();
      bet_req = 1'b1;
      bet_amt = 4'd8;
      tick();
      bet_req = 1'b0;
      n_checks++; if (number !== 11'd92) begin n_fail++; $display("[TB] FAIL mid_debit: got %0d want 92", $signed(number)); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (number !== 11'd100) begin n_fail++; $display("[TB] FAIL mid_reset_number: got %0d want 100", $signed(number)); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_busy: got %b want 0", busy); end
      n_checks++; if (spin_start !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_spin: got %b want 0", spin_start); end
      spin_done = 1'b1;
      reel0 = 3'd7; reel1 = 3'd7; reel2 = 3'd7;
      tick();
      spin_done = 1'b0;
      tick();
      n_checks++; if (number !== 11'd100) begin n_fail++; $display("[TB] FAIL late_done_number: got %0d want 100", $signed(number)); end
      n_checks++; if (last_win !== 9'd0) begin n_fail++; $display("[TB] FAIL late_done_win: got %0d want 0", last_win); end
      bal = 100;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 60; i++) begin
         spin_txn(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      end
   endtask

`ifdef SPIN_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      bet_req = 1'b1;
      bet_amt = 4'd6;
      tick();
      bet_req = 1'b0;
      repeat (9) tick();
      n_checks++; if (number !== 11'd94) begin n_fail++; $display("[TB] FAIL to_pending_number: got %0d want 94", $signed(number)); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL to_pending_busy: got %b want 1", busy); end
      tick();
      n_checks++; if (number !== 11'd100) begin n_fail++; $display("[TB] FAIL to_refund: got %0d want 100", $signed(number)); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL to_busy: got %b want 0", busy); end
      n_checks++; if (last_win !== 9'd0) begin n_fail++; $display("[TB] FAIL to_last_win: got %0d want 0", last_win); end
      bet_req = 1'b1;
      bet_amt = 4'd6;
      tick();
      bet_req = 1'b0;
      repeat (9) tick();
      spin_done = 1'b1;
      reel0 = 3'd2; reel1 = 3'd2; reel2 = 3'd5;
      tick();
      spin_done = 1'b0;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL expiry_done_busy: got %b want 1", busy); end
      tick();
      n_checks++; if (number !== 11'd106) begin n_fail++; $display("[TB] FAIL expiry_done_number: got %0d want 106", $signed(number)); end
      n_checks++; if (last_win !== 9'd12) begin n_fail++; $display("[TB] FAIL expiry_done_win: got %0d want 12", last_win); end
   endtask
`endif

   initial begin
      idle_inputs();
      rst = 1'b0;
      test_reset();
      test_basic();
      test_saturation();
      test_reject();
      test_wait_spin();
      test_reset_mid_spin();
      test_random();
`ifdef SPIN_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/credit_ledger.md
Name: credit_ledger

Overview:
- Player credit bookkeeping stage of the slot machine.
- Accepts bets and debits the wager, then starts a spin and waits for the reel stage to report the landed symbols.
- Evaluates the payout and credits it back.
- Drives the signed 11-bit two's-complement balance consumed directly by display_number, which shows a sign plus 3 digits, so the balance is held within -999..+999.

Parameters:
- INIT_CREDITS, 100, balance loaded on reset (must lie within -999..999).
- TIMEOUT_CYCLES, 50_000_000, spin watchdog length in clk cycles (used only with SPIN_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- bet_req  in  1  single-cycle bet request.
- bet_amt  in  4  wager, 1..15; 0 is ignored.
- spin_done  in  1  single-cycle pulse from reel stage; reels valid in same cycle.
- reel0, reel1, reel2  in  3 each  landed symbols 0..7.
- spin_start  out  1  single-cycle pulse to reel stage.
- number  out  11  balance, two's complement, to display_number.
- last_win  out  9  unsigned payout of most recent spin.
- bet_rej  out  1  single-cycle pulse when a bet is refused.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values:
  - number = INIT_CREDITS; last_win = 0; spin_start = 0; bet_rej = 0; busy = 0.
  - state = IDLE; latched bet = 0; latched reels = 0.
- Reset mid-operation abandons the spin with no refund and restores INIT_CREDITS.
- FSM states: IDLE, WAIT_SPIN, PAYOUT.
- IDLE:
  - bet_req=1 with bet_amt=0: ignored, no pulse.
  - bet_req=1 with bet_amt!=0 and number - bet_amt >= -999, at the next edge:
    - number <= number - bet_amt; latch bet_amt; spin_start <= 1 for exactly one cycle; state <= WAIT_SPIN.
  - bet_req=1 with bet_amt!=0 and number - bet_amt < -999: bet_rej <= 1 for one cycle; state stays IDLE; number unchanged.
- WAIT_SPIN:
  - bet_req is ignored (no bet_rej).
  - spin_done is not sampled in the cycle spin_start is high.
  - On spin_done=1: latch reel0..2; state <= PAYOUT.
- PAYOUT (exactly one cycle):
  - payout = f(latched reels) * latched bet.
  - number <= sat(number + payout); last_win <= payout; state <= IDLE.
- Latency: number reflects the debit 1 cycle after an accepted bet_req, and the payout 2 cycles after spin_done.
- Payout multiplier f:
  - all three reels equal and == 7: 20.
  - all three reels equal, other symbol: 10.
  - exactly two reels equal (any pair): 2.
  - otherwise: 0.
- Maximum payout 15*20 = 300; fits in 9 bits.
- Arithmetic:
  - Internal sums computed at 12 bits signed.
  - sat clamps to +999 upper bound; the lower bound is never crossed on credit.
- bet_req and spin_done arriving in the same cycle: each is handled only in its own state; the other is ignored.
- Out-of-state spin_done pulses (IDLE, PAYOUT) are ignored.

Optional Feature:
- Macro: SPIN_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_SPIN, cleared on entry.
  - If TIMEOUT_CYCLES elapse without spin_done: number <= number + latched bet (refund); last_win <= 0; state <= IDLE.
  - spin_done on the exact expiry cycle takes priority over the timeout.
- Undefined: no counter; WAIT_SPIN waits indefinitely.

Decomposition:
- Shared package (slot_pkg):
  - CREDIT_MAX = 999, CREDIT_MIN = -999.
  - State encoding constants.
  - Multipliers MULT_JACKPOT = 20, MULT_TRIPLE = 10, MULT_PAIR = 2, JACKPOT_SYM = 7.
  - Widths: NUM_W = 11, BET_W = 4, SYM_W = 3.
- One combinational sub-module, payout_eval: latched reels + bet in, 9-bit payout out. Unit-testable in isolation.

Test Plan:
- Reset, then bet_amt=5 -> number 95 one cycle later; spin_start high one cycle; busy=1. Then spin_done with reels 3,3,3 -> number 145 and last_win=50 two cycles after.
- Balance 990, bet 15, reels 7,7,7 -> debit to 975; payout 300 saturates number at 999; last_win=300.
- Balance -990, bet 10 -> bet_rej pulse; number stays -990 (0x422 in two's complement); no spin_start. Then bet 9 -> accepted; number -999.
- During WAIT_SPIN, a bet_req with bet_amt=4 is ignored; spin_done with reels 1,2,1 -> payout 2*bet; reels 0,1,2 -> payout 0, last_win=0.
- rst asserted in WAIT_SPIN after a bet of 8 from 100 -> next cycle number=100, state IDLE, spin_start=0; a later spin_done is ignored.
- SPIN_TIMEOUT_EN defined with TIMEOUT_CYCLES=10, bet 6 and no spin_done -> number returns 100 after 10 cycles; busy falls. Also cover spin_done on the expiry cycle -> normal payout path taken.
